// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//
// Multi-product coin vending controller. Credit is built up from 1/2/5-unit
// coins. A selection buys one of NUM_ITEMS products at its own price. Any
// leftover credit, or the whole credit on cancel, is paid back one coin per
// cycle to the hopper through a valid/ready handshake.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   coin_valid/coin  coin strobe and value (legal values 1, 2, 5)
//   sel_valid/
//   sel_item         product selection strobe and index
//   cancel           refund request (only acted on while holding credit)
//   change_ready     hopper accepts the presented change coin
//   coin_reject      one-cycle pulse, sampled coin refused
//   sel_denied       one-cycle pulse, sampled selection refused
//   delivery/
//   delivery_item    one-cycle dispense pulse and the product index
//   change_valid/
//   change_coin      change coin presented to the hopper (5, 2 or 1)
//   credit           current credit
//   busy             high while vending or paying out change
// ---------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int                            CREDIT_W   = 8,
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            ITEM_W     = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = 32'h04030202,
  parameter int                            MAX_CREDIT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [2:0]          coin,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic                delivery,
  output logic [ITEM_W-1:0]   delivery_item,
  output logic                change_valid,
  output logic [2:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  localparam logic [CREDIT_W:0] MaxCreditW = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coinReject_q, coinReject_d;
  logic                selDenied_q, selDenied_d;
  logic                delivery_q, delivery_d;
  logic [ITEM_W-1:0]   deliveryItem_q, deliveryItem_d;
  logic                changeValid_q, changeValid_d;
  logic [2:0]          changeCoin_q, changeCoin_d;
  logic                busy_q, busy_d;

  logic                coinLegal;
  logic [CREDIT_W:0]   coinSum;
  logic                coinFits;
  logic [CREDIT_W-1:0] price;
  logic                selInRange;

  // Largest hopper denomination that still fits into the remaining credit;
  // greedy payout always ends exactly at zero because a 1-unit coin exists.
  function automatic logic [2:0] largestCoin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5)) begin
      return 3'd5;
    end else if (c >= CREDIT_W'(2)) begin
      return 3'd2;
    end else if (c != '0) begin
      return 3'd1;
    end else begin
      return 3'd0;
    end
  endfunction

  // Coin acceptance test. The sum is one bit wider than the credit register
  // so the limit check cannot wrap.
  always_comb begin
    coinLegal = (coin == 3'd1) || (coin == 3'd2) || (coin == 3'd5);
    coinSum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin);
    coinFits  = coinSum <= MaxCreditW;
  end

  // Price lookup. An index beyond NUM_ITEMS finds no match, which marks the
  // selection as out of range instead of reading past the price table.
  always_comb begin
    price      = '0;
    selInRange = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == ITEM_W'(i)) begin
        price      = PRICES[i*CREDIT_W +: CREDIT_W];
        selInRange = 1'b1;
      end
    end
  end

  // Next-state logic. In IDLE/COLLECT, cancel beats a selection, which beats
  // a coin; a coin that loses out is refused. Cancel only counts when there
  // is credit to return, so in IDLE it drops out of the priority chain.
  // Every output is derived from the next state so that the registered
  // outputs always agree with the state and credit shown after the edge.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    coinReject_d = 1'b0;
    selDenied_d  = 1'b0;
    deliveryItem_d = '0;

    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && (state_q == COLLECT)) begin
          state_d      = CHANGE;
          coinReject_d = coin_valid;
        end else if (sel_valid) begin
          coinReject_d = coin_valid;
          if (selInRange && (credit_q >= price)) begin
            credit_d       = credit_q - price;
            state_d        = VEND;
            deliveryItem_d = sel_item;
          end else begin
            selDenied_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coinLegal && coinFits) begin
            credit_d = coinSum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            coinReject_d = 1'b1;
          end
        end
      end

      VEND: begin
        coinReject_d = coin_valid;
        state_d      = (credit_q != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        coinReject_d = coin_valid;
        if (change_ready) begin
          credit_d = credit_q - CREDIT_W'(changeCoin_q);
          if (credit_d == '0) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    delivery_d    = (state_d == VEND);
    changeValid_d = (state_d == CHANGE);
    changeCoin_d  = (state_d == CHANGE) ? largestCoin(credit_d) : 3'd0;
    busy_d        = (state_d == VEND) || (state_d == CHANGE);
  end

  // State, credit and all outputs are registered together; reset clears
  // everything, including any change still owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      coinReject_q   <= 1'b0;
      selDenied_q    <= 1'b0;
      delivery_q     <= 1'b0;
      deliveryItem_q <= '0;
      changeValid_q  <= 1'b0;
      changeCoin_q   <= 3'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      coinReject_q   <= coinReject_d;
      selDenied_q    <= selDenied_d;
      delivery_q     <= delivery_d;
      deliveryItem_q <= deliveryItem_d;
      changeValid_q  <= changeValid_d;
      changeCoin_q   <= changeCoin_d;
      busy_q         <= busy_d;
    end
  end

  assign coin_reject   = coinReject_q;
  assign sel_denied    = selDenied_q;
  assign delivery      = delivery_q;
  assign delivery_item = deliveryItem_q;
  assign change_valid  = changeValid_q;
  assign change_coin   = changeCoin_q;
  assign credit        = credit_q;
  assign busy          = busy_q;

endmodule
